// File: rtl/uart_arb_pkg.sv
// Shared constants, helpers and FSM encoding for uart_tx_arbiter.
// ST_ABORT is only part of the encoding when UART_TX_ARB_TIMEOUT_EN is defined.
package uart_arb_pkg;

    localparam int DEF_CLOCK_RATE = 12_000_000;
    localparam int DEF_BAUD_RATE  = 9_600;
    localparam int CYCLES_PER_BIT = DEF_CLOCK_RATE / DEF_BAUD_RATE;

    localparam logic [1:0] ENC_IDLE      = 2'd0;
    localparam logic [1:0] ENC_START     = 2'd1;
    localparam logic [1:0] ENC_WAIT_DONE = 2'd2;
`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam logic [1:0] ENC_ABORT     = 2'd3;
`endif

    typedef enum logic [1:0] {
        ST_IDLE      = ENC_IDLE,
        ST_START     = ENC_START,
        ST_WAIT_DONE = ENC_WAIT_DONE
`ifdef UART_TX_ARB_TIMEOUT_EN
        ,
        ST_ABORT     = ENC_ABORT
`endif
    } arb_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin pick: first valid requester at or above ptr_i, wrapping.
module rr_arbiter #(
    parameter int  NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               any_o
);

    logic [IDX_W:0]   sum  [NUM_REQ];
    logic [IDX_W-1:0] cand [NUM_REQ];

    // cand[gi] is the requester gi steps after the pointer, modulo NUM_REQ
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        assign sum[gi]  = {1'b0, ptr_i} + (IDX_W+1)'(gi);
        assign cand[gi] = (sum[gi] >= (IDX_W+1)'(NUM_REQ))
                        ? IDX_W'(sum[gi] - (IDX_W+1)'(NUM_REQ))
                        : sum[gi][IDX_W-1:0];
    end

    // Scan farthest offset first so the nearest valid requester is the last writer.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid_i[cand[k]]) begin
                grant_o          = '0;
                grant_o[cand[k]] = 1'b1;
                grant_idx_o      = cand[k];
                any_o            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one Uart8 transmitter among NUM_REQ byte producers.
// Define UART_TX_ARB_TIMEOUT_EN to add the watchdog and the ABORT (txEn low) recovery.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int  NUM_REQ        = 4,
    parameter int  CLOCK_RATE     = DEF_CLOCK_RATE,
    parameter int  BAUD_RATE      = DEF_BAUD_RATE,
    parameter int  TIMEOUT_CYCLES = 12 * CLOCK_RATE / BAUD_RATE,
    parameter int  ABORT_CYCLES   = CLOCK_RATE / BAUD_RATE,
    localparam int IDX_W          = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic [NUM_REQ-1:0]   reqValid,
    input  logic [8*NUM_REQ-1:0] reqData,
    output logic [NUM_REQ-1:0]   reqReady,
    output logic [NUM_REQ-1:0]   sentPulse,
    output logic [NUM_REQ-1:0]   errPulse,
    output logic [IDX_W-1:0]     grantId,
    output logic                 busy,
    output logic                 txEn,
    output logic                 txStart,
    output logic [7:0]           in,
    input  logic                 txBusy,
    input  logic                 txDone
);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   grant_id_q, grant_id_d;
    logic [7:0]         data_q, data_d;
    logic               tx_en_q, tx_en_d;
    logic [NUM_REQ-1:0] sent_q, sent_d;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [7:0]         req_bytes [NUM_REQ];
    logic [7:0]         pick_data;
    logic               accept;
    logic               complete;
    logic [IDX_W-1:0]   next_ptr;
    logic [NUM_REQ-1:0] gid_onehot;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
        assign req_bytes[gi] = reqData[8*gi +: 8];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req_valid_i (reqValid),
        .ptr_i       (ptr_q),
        .grant_o     (pick_onehot),
        .grant_idx_o (pick_idx),
        .any_o       (pick_any)
    );

    assign pick_data  = req_bytes[pick_idx];
    // Ready is withheld while reset is asserted so no producer sees a phantom transfer.
    assign accept     = resetN && (state_q == ST_IDLE) && pick_any;
    assign complete   = (state_q == ST_WAIT_DONE) && txDone && !txBusy;
    assign next_ptr   = (grant_id_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
    assign gid_onehot = NUM_REQ'(1) << grant_id_q;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(max_int(TIMEOUT_CYCLES, ABORT_CYCLES) + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] AB_LAST = CNT_W'(ABORT_CYCLES - 1);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] err_q, err_d;
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        data_d     = data_q;
        tx_en_d    = 1'b1;
        sent_d     = '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_START;
                    grant_id_d = pick_idx;
                    data_d     = pick_data;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            ST_START: begin
                if (txBusy) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (complete) begin
                    state_d = ST_IDLE;
                    sent_d  = gid_onehot;
                    ptr_d   = next_ptr;
                end
            end
`ifdef UART_TX_ARB_TIMEOUT_EN
            ST_ABORT: begin
                tx_en_d = 1'b0;
                if (cnt_q == AB_LAST) begin
                    state_d = ST_IDLE;
                    ptr_d   = next_ptr;
                    tx_en_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
`ifdef UART_TX_ARB_TIMEOUT_EN
        // Watchdog overrides START->WAIT_DONE but never a completion seen the same cycle.
        if ((state_q == ST_START || state_q == ST_WAIT_DONE) && !complete) begin
            if (cnt_q == TO_LAST) begin
                state_d = ST_ABORT;
                err_d   = gid_onehot;
                tx_en_d = 1'b0;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            grant_id_q <= '0;
            data_q     <= '0;
            tx_en_q    <= 1'b0;
            sent_q     <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            data_q     <= data_d;
            tx_en_q    <= tx_en_d;
            sent_q     <= sent_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    assign reqReady  = accept ? pick_onehot : '0;
    assign sentPulse = sent_q;
    assign grantId   = grant_id_q;
    assign busy      = (state_q != ST_IDLE);
    assign txEn      = tx_en_q;
    assign txStart   = (state_q == ST_START);
    assign in        = data_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
    assign errPulse  = err_q;
`else
    assign errPulse  = '0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: behavioural UART stub, cycle reference model,
// directed scenarios and randomized traffic. Honors UART_TX_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 12 * 12_000_000 / 9_600;   // 15000
    localparam int AB = 12_000_000 / 9_600;        // 1250
`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           resetN;
    logic [N-1:0]   reqValid;
    logic [8*N-1:0] reqData;
    logic [N-1:0]   reqReady, sentPulse, errPulse;
    logic [1:0]     grantId;
    logic           busy, txEn, txStart;
    logic [7:0]     tx_in;
    logic           txBusy, txDone;

    uart_tx_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .resetN    (resetN),
        .reqValid  (reqValid),
        .reqData   (reqData),
        .reqReady  (reqReady),
        .sentPulse (sentPulse),
        .errPulse  (errPulse),
        .grantId   (grantId),
        .busy      (busy),
        .txEn      (txEn),
        .txStart   (txStart),
        .in        (tx_in),
        .txBusy    (txBusy),
        .txDone    (txDone)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // reference model of the arbiter
    bit           m_active, m_started, m_abort, m_txen;
    int           m_ptr, m_gid, m_cycles, m_aleft;
    logic [7:0]   m_data;
    logic [N-1:0] m_sent, m_err;

    // behavioural UART transmitter stub
    bit   s_active, s_done, stuck, noise;
    int   s_delay, s_len;
    logic samp_txStart, samp_txEn;
    logic [7:0] samp_in;

    logic [N-1:0] last_ready;
    logic         last_txEn, last_busy;
    int   grant_log[$], err_log[$], acc_log[$], acc_cyc[$], err_cyc[$];
    logic [7:0] s_bytes[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int first_valid(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[k]) return k;
        return -1;
    endfunction

    task automatic model_update();
        int fv;
        if (!resetN) begin
            m_active = 0; m_started = 0; m_abort = 0; m_txen = 0;
            m_ptr = 0; m_gid = 0; m_data = 8'h00; m_sent = '0; m_err = '0;
        end else begin
            m_sent = '0;
            m_err  = '0;
            if (m_abort) begin
                m_aleft--;
                if (m_aleft == 0) begin
                    m_abort = 0;
                    m_ptr   = (m_gid + 1) % N;
                end
            end else if (m_active) begin
                m_cycles++;
                if (m_started && txDone && !txBusy) begin
                    m_sent[m_gid] = 1'b1;
                    m_active = 0;
                    m_ptr = (m_gid + 1) % N;
                end else if (TO_EN && m_cycles == TO) begin
                    m_err[m_gid] = 1'b1;
                    m_active = 0;
                    m_abort = 1;
                    m_aleft = AB;
                end else if (!m_started && txBusy) begin
                    m_started = 1;
                end
            end else begin
                fv = first_valid(reqValid, m_ptr);
                if (fv >= 0) begin
                    m_active = 1; m_started = 0; m_cycles = 0;
                    m_gid = fv;
                    m_data = reqData[8*fv +: 8];
                end
            end
            m_txen = !m_abort;
        end
    endtask

    task automatic stub_update();
        s_done = 0;
        if (!samp_txEn) begin
            s_active = 0;
        end else if (s_active) begin
            if (s_delay > 0) s_delay--;
            else if (s_len > 1) s_len--;
            else begin
                s_active = 0;
                s_done = 1;
            end
        end else if (samp_txStart && !stuck) begin
            s_active = 1;
            s_delay  = $urandom_range(0, 2);
            s_len    = $urandom_range(2, 10);
            s_bytes.push_back(samp_in);
        end
    endtask

    task automatic step(input logic rn, input logic [N-1:0] v, input logic [8*N-1:0] d);
        int fv;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        resetN   = rn;
        reqValid = v;
        reqData  = d;
        txBusy   = s_active && (s_delay == 0);
        txDone   = s_done || (noise && txBusy && ($urandom_range(0, 5) == 0));
        #1;
        fv = first_valid(reqValid, m_ptr);
        exp_rdy = (rn && !m_active && !m_abort && fv >= 0) ? (N'(1) << fv) : '0;
        check("reqReady", reqReady, exp_rdy);
        check("txStart", txStart, m_active && !m_started);
        check("busy", busy, m_active || m_abort);
        check("txEn", txEn, m_txen);
        check("grantId", grantId, m_gid);
        check("in", tx_in, m_data);
        check("sentPulse", sentPulse, m_sent);
        check("errPulse", errPulse, m_err);
        last_ready   = reqReady;
        last_txEn    = txEn;
        last_busy    = busy;
        samp_txStart = txStart;
        samp_txEn    = txEn;
        samp_in      = tx_in;
        if ((reqReady & reqValid) != '0) begin
            acc_log.push_back(onehot_idx(reqReady));
            acc_cyc.push_back(cyc);
        end
        if (sentPulse != '0) begin
            grant_log.push_back(onehot_idx(sentPulse));
            $display("[TB] cycle %0d sent req %0d byte %02h", cyc, onehot_idx(sentPulse), tx_in);
        end
        if (errPulse != '0) begin
            err_log.push_back(onehot_idx(errPulse));
            err_cyc.push_back(cyc);
            $display("[TB] cycle %0d timeout abort req %0d", cyc, onehot_idx(errPulse));
        end
        cyc++;
        @(posedge clk);
        model_update();
        stub_update();
    endtask

    task automatic clear_logs();
        grant_log.delete(); err_log.delete(); acc_log.delete();
        acc_cyc.delete(); err_cyc.delete(); s_bytes.delete();
    endtask

    initial begin
        logic [8*N-1:0] d;
        logic [N-1:0]   pend;
        int             low_cnt;

        s_active = 0; s_done = 0; stuck = 0; noise = 0; s_delay = 0; s_len = 0;
        samp_txStart = 0; samp_txEn = 0; samp_in = 0;
        m_active = 0; m_started = 0; m_abort = 0; m_txen = 0;
        m_ptr = 0; m_gid = 0; m_data = 0; m_sent = '0; m_err = '0; m_cycles = 0; m_aleft = 0;
        resetN = 0; reqValid = '0; reqData = '0; txBusy = 0; txDone = 0;

        repeat (3) step(1'b0, '0, '0);
        check("rst_txEn", last_txEn, 1'b0);
        check("rst_busy", last_busy, 1'b0);

        // single request from requester 1
        d = '0; d[15:8] = 8'h45;
        step(1'b1, 4'b0010, d);
        check("t1_ready", last_ready, 4'b0010);
        for (int i = 0; i < 300 && grant_log.size() < 1; i++) step(1'b1, '0, d);
        repeat (20) step(1'b1, '0, d);
        check("t1_nsent", grant_log.size(), 1);
        check("t1_id", grant_log[0], 1);
        check("t1_rx", s_bytes[0], 8'h45);

        // all four at once from ptr 0
        repeat (2) step(1'b0, '0, '0);
        clear_logs();
        d = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        pend = 4'b1111;
        for (int i = 0; i < 600 && grant_log.size() < 4; i++) begin
            step(1'b1, pend, d);
            pend &= ~last_ready;
        end
        check("t2_nsent", grant_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("t2_order", grant_log[i], i);
            check("t2_rx", s_bytes[i], 8'hA0 + i);
        end

        // two persistent requesters must alternate
        clear_logs();
        d = '0; d[7:0] = 8'h7F; d[31:24] = 8'h01;
        for (int i = 0; i < 1500 && grant_log.size() < 6; i++) step(1'b1, 4'b1001, d);
        check("t3_nsent", grant_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check("t3_order", grant_log[i], (i % 2 == 0) ? 0 : 3);
            check("t3_rx", s_bytes[i], (i % 2 == 0) ? 8'h7F : 8'h01);
        end

        // reset pulse while waiting for the UART to finish
        repeat (2) step(1'b0, '0, '0);
        clear_logs();
        d = 32'h44332211;
        step(1'b1, 4'b0100, d);
        for (int i = 0; i < 40 && !(m_active && m_started); i++) step(1'b1, '0, d);
        step(1'b0, 4'b1111, d);
        step(1'b1, 4'b1111, d);
        check("t4_ready", last_ready, 4'b0001);
        check("t4_txEn", last_txEn, 1'b0);
        check("t4_nosent", grant_log.size(), 0);
        for (int i = 0; i < 300 && grant_log.size() < 1; i++) step(1'b1, '0, d);
        check("t4_first", grant_log[0], 0);

        // randomized traffic with glitchy txDone and occasional resets
        noise = 1;
        clear_logs();
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 399) != 0), N'($urandom), {$urandom});
        noise = 0;
        check("rand_activity", grant_log.size() > 50, 1'b1);

        // UART that never reports busy
        repeat (2) step(1'b0, '0, '0);
        clear_logs();
        stuck = 1;
        pend = 4'b1100;
        d = 32'h03020100;
        low_cnt = 0;
`ifdef UART_TX_ARB_TIMEOUT_EN
        for (int i = 0; i < TO + AB + 100 && acc_log.size() < 2; i++) begin
            step(1'b1, pend, d);
            pend &= ~last_ready;
            if (i > 0 && !last_txEn) low_cnt++;
        end
        check("to_nerr", err_log.size(), 1);
        check("to_err_id", err_log[0], 2);
        check("to_latency", err_cyc[0] - acc_cyc[0], TO + 1);
        check("to_txen_low", low_cnt, AB);
        check("to_next_grant", acc_log[1], 3);
`else
        for (int i = 0; i < 400; i++) begin
            step(1'b1, pend, d);
            pend &= ~last_ready;
        end
        check("stall_nerr", err_log.size(), 0);
        check("stall_busy", last_busy, 1'b1);
        check("stall_ngrant", acc_log.size(), 1);
`endif
        stuck = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
